// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that drains the ALU and LSB result FIFOs onto one registered CDB.
// Optional grant/conflict statistics counters are enabled with the CDB_STATS_EN macro.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rollback,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        alu_pc_out,
  input  logic               lsb_valid,
  output logic               lsb_ready,
  input  logic [ENTRY_W-1:0] lsb_entry,
  input  logic [31:0]        lsb_result,
  output logic               cdb_valid,
  output logic               cdb_src,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [31:0]        cdb_result,
  output logic [31:0]        cdb_pc_out
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]        stat_alu_cnt,
  output logic [31:0]        stat_lsb_cnt,
  output logic [31:0]        stat_conflict_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [ENTRY_W+63:0] r_alu_mem [FIFO_DEPTH];
  logic [ENTRY_W+31:0] r_lsb_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_alu_wp, r_alu_rp, r_lsb_wp, r_lsb_rp;
  logic [CW-1:0]       r_alu_cnt, r_lsb_cnt;
  logic                r_last_lsb;
  logic                r_cdb_valid, r_cdb_src;
  logic [ENTRY_W-1:0]  r_cdb_entry;
  logic [31:0]         r_cdb_result, r_cdb_pc_out;
  logic                w_act, w_flush, w_alu_ne, w_lsb_ne, w_gnt_alu, w_gnt_lsb;
  logic                w_alu_push, w_lsb_push, w_alu_pop, w_lsb_pop;
  logic [ENTRY_W+63:0] w_alu_head;
  logic [ENTRY_W+31:0] w_lsb_head;
  assign w_act      = rdy && !rollback;
  assign w_flush    = rdy && rollback;
  assign alu_ready  = (r_alu_cnt < CW'(FIFO_DEPTH)) && w_act;
  assign lsb_ready  = (r_lsb_cnt < CW'(FIFO_DEPTH)) && w_act;
  assign w_alu_push = alu_valid && alu_ready;
  assign w_lsb_push = lsb_valid && lsb_ready;
  assign w_alu_ne   = r_alu_cnt != '0;
  assign w_lsb_ne   = r_lsb_cnt != '0;
  // On a conflict the source that did not win last time gets the bus.
  assign w_gnt_alu  = w_alu_ne && (!w_lsb_ne || r_last_lsb);
  assign w_gnt_lsb  = w_lsb_ne && !w_gnt_alu;
  assign w_alu_pop  = w_act && w_gnt_alu;
  assign w_lsb_pop  = w_act && w_gnt_lsb;
  assign w_alu_head = r_alu_mem[r_alu_rp];
  assign w_lsb_head = r_lsb_mem[r_lsb_rp];
  assign cdb_valid  = r_cdb_valid;
  assign cdb_src    = r_cdb_src;
  assign cdb_entry  = r_cdb_entry;
  assign cdb_result = r_cdb_result;
  assign cdb_pc_out = r_cdb_pc_out;
  always_ff @(posedge clk) begin
    if (w_alu_push) r_alu_mem[r_alu_wp] <= {alu_entry, alu_result, alu_pc_out};
    if (w_lsb_push) r_lsb_mem[r_lsb_wp] <= {lsb_entry, lsb_result};
  end
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_alu_wp  <= '0;
      r_alu_rp  <= '0;
      r_alu_cnt <= '0;
      r_lsb_wp  <= '0;
      r_lsb_rp  <= '0;
      r_lsb_cnt <= '0;
    end else begin
      r_alu_wp  <= r_alu_wp + AW'(w_alu_push);
      r_alu_rp  <= r_alu_rp + AW'(w_alu_pop);
      r_alu_cnt <= r_alu_cnt + CW'(w_alu_push) - CW'(w_alu_pop);
      r_lsb_wp  <= r_lsb_wp + AW'(w_lsb_push);
      r_lsb_rp  <= r_lsb_rp + AW'(w_lsb_pop);
      r_lsb_cnt <= r_lsb_cnt + CW'(w_lsb_push) - CW'(w_lsb_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_src    <= 1'b0;
      r_cdb_entry  <= '1;
      r_cdb_result <= '0;
      r_cdb_pc_out <= '0;
      r_last_lsb   <= 1'b1;
    end else if (w_flush) begin
      r_cdb_valid <= 1'b0;
    end else if (rdy) begin
      r_cdb_valid <= w_gnt_alu || w_gnt_lsb;
      if (w_gnt_alu) begin
        r_cdb_src    <= 1'b0;
        r_cdb_entry  <= w_alu_head[ENTRY_W+63:64];
        r_cdb_result <= w_alu_head[63:32];
        r_cdb_pc_out <= w_alu_head[31:0];
        r_last_lsb   <= 1'b0;
      end else if (w_gnt_lsb) begin
        r_cdb_src    <= 1'b1;
        r_cdb_entry  <= w_lsb_head[ENTRY_W+31:32];
        r_cdb_result <= w_lsb_head[31:0];
        r_cdb_pc_out <= '0;
        r_last_lsb   <= 1'b1;
      end
    end
  end
`ifdef CDB_STATS_EN
  logic [31:0] r_stat_alu, r_stat_lsb, r_stat_conf;
  assign stat_alu_cnt      = r_stat_alu;
  assign stat_lsb_cnt      = r_stat_lsb;
  assign stat_conflict_cnt = r_stat_conf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_alu  <= '0;
      r_stat_lsb  <= '0;
      r_stat_conf <= '0;
    end else if (rdy) begin
      r_stat_alu  <= r_stat_alu + 32'(w_alu_pop);
      r_stat_lsb  <= r_stat_lsb + 32'(w_lsb_pop);
      r_stat_conf <= r_stat_conf + 32'(w_alu_ne && w_lsb_ne);
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: queue-based reference model feeds a scoreboard; a monitor compares every CDB edge.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  typedef struct {logic v; logic s; logic [4:0] e; logic [31:0] r; logic [31:0] p;} bus_t;
  typedef struct {logic [4:0] e; logic [31:0] r; logic [31:0] p;} ent_t;
  logic clk = 0, rst = 1, rdy = 0, rollback = 0, alu_valid = 0, lsb_valid = 0;
  logic [4:0] alu_entry = 0, lsb_entry = 0;
  logic [31:0] alu_result = 0, alu_pc_out = 0, lsb_result = 0;
  logic alu_ready, lsb_ready, cdb_valid, cdb_src;
  logic [4:0] cdb_entry;
  logic [31:0] cdb_result, cdb_pc_out;
  int checks = 0, errors = 0;
  bus_t exp_q[$];
  bus_t bus = '{1'b0, 1'b0, 5'h1f, 32'h0, 32'h0};
  ent_t aq[$], lq[$];
  bit last_lsb = 1;
  int unsigned ms_a = 0, ms_l = 0, ms_c = 0;
  bit da, dl;
  logic mon_rst;
  bus_t mon_e;
`ifdef CDB_STATS_EN
  logic [31:0] stat_alu_cnt, stat_lsb_cnt, stat_conflict_cnt;
`endif
  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ENTRY_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_entry(alu_entry),
    .alu_result(alu_result), .alu_pc_out(alu_pc_out),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_entry(cdb_entry),
    .cdb_result(cdb_result), .cdb_pc_out(cdb_pc_out)
`ifdef CDB_STATS_EN
    , .stat_alu_cnt(stat_alu_cnt), .stat_lsb_cnt(stat_lsb_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Drive one cycle of stimulus and advance the reference model by one edge.
  task automatic cyc(input bit r, input bit rb, input bit av, input logic [4:0] ae,
                     input logic [31:0] ar, input logic [31:0] ap, input bit lv,
                     input logic [4:0] le, input logic [31:0] lr, output bit acc_a, output bit acc_l);
    bit ga, gl;
    rdy = r; rollback = rb;
    alu_valid = av; alu_entry = ae; alu_result = ar; alu_pc_out = ap;
    lsb_valid = lv; lsb_entry = le; lsb_result = lr;
    #1;
    acc_a = (aq.size() < DEPTH) && r && !rb;
    acc_l = (lq.size() < DEPTH) && r && !rb;
    chk("alu_ready", 64'(alu_ready), 64'(acc_a));
    chk("lsb_ready", 64'(lsb_ready), 64'(acc_l));
    acc_a = acc_a && av;
    acc_l = acc_l && lv;
    if (r && aq.size() > 0 && lq.size() > 0) ms_c++;
    if (r && rb) begin
      aq.delete(); lq.delete(); bus.v = 0;
    end else if (r) begin
      ga = aq.size() > 0 && (lq.size() == 0 || last_lsb);
      gl = lq.size() > 0 && !ga;
      if (ga) begin
        bus = '{1'b1, 1'b0, aq[0].e, aq[0].r, aq[0].p};
        void'(aq.pop_front()); last_lsb = 0; ms_a++;
      end else if (gl) begin
        bus = '{1'b1, 1'b1, lq[0].e, lq[0].r, 32'h0};
        void'(lq.pop_front()); last_lsb = 1; ms_l++;
      end else bus.v = 0;
      if (acc_a) aq.push_back('{ae, ar, ap});
      if (acc_l) lq.push_back('{le, lr, 32'h0});
    end
    exp_q.push_back(bus);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, da, dl);
  endtask
  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    if (!mon_rst) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else begin
        mon_e = exp_q.pop_front();
        chk("cdb_valid", 64'(cdb_valid), 64'(mon_e.v));
        chk("cdb_src", 64'(cdb_src), 64'(mon_e.s));
        chk("cdb_entry", 64'(cdb_entry), 64'(mon_e.e));
        chk("cdb_result", 64'(cdb_result), 64'(mon_e.r));
        chk("cdb_pc_out", 64'(cdb_pc_out), 64'(mon_e.p));
      end
    end
  end
  initial begin
    int k;
    bit aa, al;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_src", 64'(cdb_src), 64'(0));
    chk("rst_entry", 64'(cdb_entry), 64'h1f);
    chk("rst_result", 64'(cdb_result), 64'(0));
    chk("rst_pc", 64'(cdb_pc_out), 64'(0));
    cyc(1, 0, 1, 3, 32'h11, 32'h40, 0, 0, 0, da, dl);
    idle(3);
    cyc(1, 0, 1, 1, 32'ha1, 32'h100, 1, 2, 32'hb2, da, dl);
    idle(3);
    cyc(1, 0, 1, 5, 32'ha5, 32'h104, 1, 6, 32'hb6, da, dl);
    cyc(1, 0, 1, 7, 32'ha7, 32'h108, 1, 8, 32'hb8, da, dl);
    idle(4);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 5'(i), 32'h1000 + i, 32'h2000 + i, k < 5, 5'(16 + k), 32'h3000 + k, aa, al);
      if (al) k++;
    end
    chk("s3_all_lsb_accepted", 64'(k), 64'(5));
    idle(14);
    cyc(1, 0, 1, 9, 32'h9, 32'h9, 1, 10, 32'ha, da, dl);
    cyc(1, 0, 1, 11, 32'hb, 32'hb, 1, 12, 32'hc, da, dl);
    cyc(1, 1, 1, 13, 32'hd, 32'hd, 1, 14, 32'he, da, dl);
    idle(4);
    cyc(1, 0, 1, 15, 32'hf, 32'hf, 1, 16, 32'h10, da, dl);
    cyc(1, 0, 1, 17, 32'h11, 32'h11, 1, 18, 32'h12, da, dl);
    for (int i = 0; i < 3; i++) cyc(0, i == 1, 1, 19, 32'h13, 32'h13, 1, 20, 32'h14, da, dl);
    idle(6);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 60, 5'($urandom), $urandom, $urandom,
          $urandom_range(0, 99) < 60, 5'($urandom), $urandom, da, dl);
    cyc(1, 0, 1, 21, 32'h21, 32'h21, 1, 22, 32'h22, da, dl);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, da, dl);
    idle(3);
    chk("sb_drain", 64'(exp_q.size()), 64'(0));
`ifdef CDB_STATS_EN
    chk("stat_alu", 64'(stat_alu_cnt), 64'(ms_a));
    chk("stat_lsb", 64'(stat_lsb_cnt), 64'(ms_l));
    chk("stat_conflict", 64'(stat_conflict_cnt), 64'(ms_c));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
